// File: rtl/stack_controller.sv
// ==== stack_controller: request sequencer for the register-file stack datapath ====
// Rev 1.0 -- optional PEEK operation enabled by defining STACK_CTRL_PEEK_EN
`default_nettype none

module stack_controller #(
  parameter int DEPTH = 8,
  parameter int SIZE  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_req,
  input  logic                     pop_req,
`ifdef STACK_CTRL_PEEK_EN
  input  logic                     peek_req,
`endif
  input  logic                     clear_err,
  input  logic                     zero,
  input  logic                     msb,
  input  logic [SIZE-1:0]          stack_top,
  output logic                     push,
  output logic                     pop,
  output logic [SIZE-1:0]          pop_data,
  output logic                     ack,
  output logic                     err,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POP  = 3'd2,
    S_ACK  = 3'd3,
    S_ERR  = 3'd4
`ifdef STACK_CTRL_PEEK_EN
    , S_PEEK = 3'd5
`endif
  } state_t;

  state_t          state_q;
  logic            push_q, pop_q, ack_q, err_q, ovf_q, unf_q, busy_q;
  logic [SIZE-1:0] pop_data_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      busy_q     <= 1'b0;
      pop_data_q <= '0;
      count_q    <= '0;
    end else begin
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      // Clear first so an error raised in the same cycle overrides it below.
      if (clear_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (push_req) begin
            busy_q <= 1'b1;
            if (msb) begin
              state_q <= S_ERR;
              ovf_q   <= 1'b1;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_PUSH;
              push_q  <= 1'b1;
            end
          end else if (pop_req) begin
            busy_q <= 1'b1;
            if (zero) begin
              state_q <= S_ERR;
              unf_q   <= 1'b1;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_POP;
              pop_q   <= 1'b1;
            end
          end
`ifdef STACK_CTRL_PEEK_EN
          else if (peek_req) begin
            busy_q <= 1'b1;
            if (zero) begin
              state_q <= S_ERR;
              unf_q   <= 1'b1;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_PEEK;
            end
          end
`endif
        end
        S_PUSH: begin
          if (count_q != C_FULL) count_q <= count_q + CW'(1);
          ack_q   <= 1'b1;
          state_q <= S_ACK;
        end
        S_POP: begin
          pop_data_q <= stack_top;
          if (count_q != '0) count_q <= count_q - CW'(1);
          ack_q   <= 1'b1;
          state_q <= S_ACK;
        end
`ifdef STACK_CTRL_PEEK_EN
        S_PEEK: begin
          pop_data_q <= stack_top;
          ack_q      <= 1'b1;
          state_q    <= S_ACK;
        end
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign push      = push_q;
  assign pop       = pop_q;
  assign pop_data  = pop_data_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign busy      = busy_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_controller.sv
// ==== tb_stack_controller: scoreboard bench with a behavioural stack datapath and reference ====
// Rev 1.0
`default_nettype none

module tb_stack_controller;

  localparam int DEPTH = 8;
  localparam int SIZE  = 6;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            push_req = 1'b0;
  logic            pop_req = 1'b0;
`ifdef STACK_CTRL_PEEK_EN
  logic            peek_req = 1'b0;
`endif
  logic            clear_err = 1'b0;
  logic            zero, msb;
  logic [SIZE-1:0] stack_top;
  logic            push, pop, ack, err, overflow, underflow, busy;
  logic [SIZE-1:0] pop_data;
  logic [CW-1:0]   count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_controller #(.DEPTH(DEPTH), .SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .push_req  (push_req),
    .pop_req   (pop_req),
`ifdef STACK_CTRL_PEEK_EN
    .peek_req  (peek_req),
`endif
    .clear_err (clear_err),
    .zero      (zero),
    .msb       (msb),
    .stack_top (stack_top),
    .push      (push),
    .pop       (pop),
    .pop_data  (pop_data),
    .ack       (ack),
    .err       (err),
    .overflow  (overflow),
    .underflow (underflow),
    .busy      (busy),
    .count     (count)
  );

  // Register-file stack datapath driven by the controller strobes.
  logic [SIZE-1:0] dp_mem [DEPTH];
  logic [CW-1:0]   dp_cnt;
  logic [CW-2:0]   top_idx;
  logic [SIZE-1:0] wdata = '0;

  always @(posedge clk) begin
    if (reset) dp_cnt <= '0;
    else if (push) begin
      dp_mem[dp_cnt[CW-2:0]] <= wdata;
      dp_cnt <= dp_cnt + CW'(1);
    end else if (pop) dp_cnt <= dp_cnt - CW'(1);
  end

  assign top_idx   = dp_cnt[CW-2:0] - (CW-1)'(1);
  assign zero      = (dp_cnt == '0);
  assign msb       = dp_cnt[CW-1];
  assign stack_top = zero ? '0 : dp_mem[top_idx];

  // Reference: a plain queue of words plus the expected sticky flags.
  typedef struct {
    int err; int pd; int cnt; int ovf; int unf; int npush; int npop;
  } exp_t;

  exp_t            sb[$];
  logic [SIZE-1:0] ref_stk[$];
  int              ref_pd  = 0;
  int              ref_ovf = 0;
  int              ref_unf = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic ref_reset();
    ref_stk.delete();
    ref_pd  = 0;
    ref_ovf = 0;
    ref_unf = 0;
  endtask

  // kind: 0 push, 1 pop, 2 peek
  task automatic model_op(input int kind, input logic [SIZE-1:0] d, output bit ok);
    exp_t e;
    ok = 1'b1;
    e.npush = 0;
    e.npop  = 0;
    if (kind == 0) begin
      if (ref_stk.size() == DEPTH) begin ok = 1'b0; ref_ovf = 1; end
      else begin ref_stk.push_back(d); e.npush = 1; end
    end else if (ref_stk.size() == 0) begin
      ok = 1'b0;
      ref_unf = 1;
    end else if (kind == 1) begin
      ref_pd = int'(ref_stk.pop_back());
      e.npop = 1;
    end else begin
      ref_pd = int'(ref_stk[ref_stk.size()-1]);
    end
    e.err = ok ? 0 : 1;
    e.pd  = ref_pd;
    e.cnt = ref_stk.size();
    e.ovf = ref_ovf;
    e.unf = ref_unf;
    sb.push_back(e);
  endtask

  // Monitor: strobe accounting and scoreboard comparison on every ack.
  int n_push = 0;
  int n_pop  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      n_push = 0;
      n_pop  = 0;
    end else begin
      if (push || pop) check("strobe_overlap", int'(push && pop), 0);
      n_push += int'(push);
      n_pop  += int'(pop);
      if (ack) begin
        if (sb.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          e = sb.pop_front();
          check("err", int'(err), e.err);
          check("pop_data", int'(pop_data), e.pd);
          check("count", int'(count), e.cnt);
          check("overflow", int'(overflow), e.ovf);
          check("underflow", int'(underflow), e.unf);
          check("push_strobes", n_push, e.npush);
          check("pop_strobes", n_pop, e.npop);
          check("busy_at_ack", int'(busy), 1);
        end
        n_push = 0;
        n_pop  = 0;
      end
    end
  end

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      clear_err = 1'b0;
      lat++;
    end while (!ack && lat < 12);
  endtask

  task automatic set_req(input int kind, input logic v);
    if (kind == 0) push_req = v;
    else if (kind == 1) pop_req = v;
`ifdef STACK_CTRL_PEEK_EN
    else peek_req = v;
`endif
  endtask

  // Called in an IDLE cycle (#1 after the edge); returns in the next IDLE cycle.
  task automatic do_op(input int kind, input logic [SIZE-1:0] d, input bit clr);
    bit ok;
    int lat;
    if (clr) begin
      ref_ovf = 0;
      ref_unf = 0;
      clear_err = 1'b1;
    end
    model_op(kind, d, ok);
    wdata = d;
    set_req(kind, 1'b1);
    wait_ack(lat);
    check("latency", lat, ok ? 2 : 1);
    set_req(kind, 1'b0);
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    ref_ovf = 0;
    ref_unf = 0;
    check("clear_overflow", int'(overflow), 0);
    check("clear_underflow", int'(underflow), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    push_req = 1'b0;
    pop_req  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    ref_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok1, ok2;
    int lat;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_push", int'(push), 0);
    check("rst_pop", int'(pop), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_err", int'(err), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_unf", int'(underflow), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pop_data", int'(pop_data), 0);
    check("rst_count", int'(count), 0);
    reset = 1'b0;

    // Request raised in the very cycle reset drops, then LIFO order.
    do_op(0, 6'h05, 1'b0);
    do_op(0, 6'h2A, 1'b0);
    do_op(0, 6'h11, 1'b0);
    repeat (3) do_op(1, '0, 1'b0);

    // Underflow straight after reset leaves pop_data at 0.
    apply_reset();
    do_op(1, '0, 1'b0);
    do_clear();

    // Fill, overflow, sticky flag persists, then clear.
    for (int i = 0; i < DEPTH; i++) do_op(0, SIZE'($urandom), 1'b0);
    do_op(0, 6'h3C, 1'b0);
    do_op(1, '0, 1'b0);
    do_clear();

    // Simultaneous requests: push wins, pop follows on the next IDLE.
    apply_reset();
    do_op(0, 6'h0A, 1'b0);
    do_op(0, 6'h0B, 1'b0);
    model_op(0, 6'h0C, ok1);
    model_op(1, '0, ok2);
    wdata = 6'h0C;
    push_req = 1'b1;
    pop_req  = 1'b1;
    wait_ack(lat);
    check("both_push_latency", lat, 2);
    push_req = 1'b0;
    wait_ack(lat);
    check("both_pop_latency", lat, 3);
    pop_req = 1'b0;
    @(posedge clk); #1;

    // Reset in the push-strobe cycle aborts the operation with no ack.
    push_req = 1'b1;
    wdata = 6'h15;
    @(posedge clk); #1;
    check("abort_strobe", int'(push), 1);
    reset = 1'b1;
    push_req = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", int'(busy), 0);
    check("abort_ack", int'(ack), 0);
    check("abort_count", int'(count), 0);
    check("abort_push", int'(push), 0);
    reset = 1'b0;
    ref_reset();

`ifdef STACK_CTRL_PEEK_EN
    do_op(0, 6'h3F, 1'b0);
    do_op(2, '0, 1'b0);
    do_op(1, '0, 1'b0);
    do_op(2, '0, 1'b0);
    do_clear();
`endif

    // Randomised traffic with alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 200; i++) begin
      int r, kind;
      r = $urandom_range(0, 99);
      if (((i / 25) % 2) == 0) kind = (r < 75) ? 0 : 1;
      else kind = (r < 25) ? 0 : 1;
`ifdef STACK_CTRL_PEEK_EN
      if ((r % 10) == 0) kind = 2;
`endif
      do_op(kind, SIZE'($urandom), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
